// File: rtl/game_time_ctrl.sv
// Session sequencer for the game timer: idle/run/pause/over FSM, 1 s prescaler and limit compare.
// Optional blinking near-limit warning is built only when GAME_TIME_WARN_EN is defined.
module game_time_ctrl #(
   parameter int CLK_DIV   = 50_000_000,
   parameter int DIV_W     = 26,
   parameter int WARN_SECS = 10
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_game_over,
   input  logic [3:0]  i_time_1s,
   input  logic [3:0]  i_time_10s,
   input  logic [3:0]  i_time_100s,
   input  logic        i_time_max_flag,
   input  logic [11:0] i_limit_bcd,
   output logic        o_time_rst,
   output logic        o_tick_1s,
   output logic [1:0]  o_state,
   output logic        o_timeout,
   output logic        o_warn
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam logic [DIV_W-1:0] LP_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] LP_ONE  = DIV_W'(1);

   state_t           r_state;
   logic [DIV_W-1:0] r_pre;
   logic             r_tick;
   logic             r_time_rst;
   logic             r_timeout;

   logic [11:0]      w_time_bcd;
   logic             w_hit;

   assign w_time_bcd = {i_time_100s, i_time_10s, i_time_1s};
   assign w_hit      = (i_limit_bcd != 12'h000) && (w_time_bcd == i_limit_bcd);

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         r_state    <= ST_IDLE;
         r_pre      <= LP_LOAD;
         r_tick     <= 1'b0;
         r_time_rst <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_pre     <= LP_LOAD;
               r_timeout <= 1'b0;
               if (i_start) begin
                  r_state    <= ST_RUN;
                  r_time_rst <= 1'b1;
               end
            end
            ST_RUN: begin
               // Terminal count always emits its tick, even when leaving RUN this cycle.
               if (r_pre == '0) begin
                  r_tick <= 1'b1;
                  r_pre  <= LP_LOAD;
               end else begin
                  r_pre <= r_pre - LP_ONE;
               end
               if (w_hit) r_timeout <= 1'b1;
               if (i_game_over || r_timeout || i_time_max_flag) r_state <= ST_OVER;
               else if (i_pause)                                r_state <= ST_PAUSE;
            end
            ST_PAUSE: begin
               if (i_game_over)  r_state <= ST_OVER;
               else if (i_pause) r_state <= ST_RUN;
            end
            ST_OVER: begin
               r_pre <= LP_LOAD;
               if (i_start) begin
                  r_state    <= ST_IDLE;
                  r_time_rst <= 1'b0;
                  r_timeout  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign o_state    = r_state;
   assign o_tick_1s  = r_tick;
   assign o_time_rst = r_time_rst;
   assign o_timeout  = r_timeout;

`ifdef GAME_TIME_WARN_EN
   localparam logic signed [10:0] LP_WARN = 11'(WARN_SECS);

   logic [9:0]         w_time_bin;
   logic [9:0]         w_limit_bin;
   logic signed [10:0] w_diff;
   logic               w_in_win;
   logic               r_warn;
   logic               r_win;

   assign w_time_bin  = 10'(i_time_100s) * 10'd100 + 10'(i_time_10s) * 10'd10 + 10'(i_time_1s);
   assign w_limit_bin = 10'(i_limit_bcd[11:8]) * 10'd100 + 10'(i_limit_bcd[7:4]) * 10'd10
                      + 10'(i_limit_bcd[3:0]);
   assign w_diff      = $signed({1'b0, w_limit_bin}) - $signed({1'b0, w_time_bin});
   assign w_in_win    = (i_limit_bcd != 12'h000) && (w_diff > 11'sd0) && (w_diff <= LP_WARN);

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         r_warn <= 1'b0;
         r_win  <= 1'b0;
      end else if (!((r_state == ST_RUN) || (r_state == ST_PAUSE)) || !w_in_win) begin
         r_warn <= 1'b0;
         r_win  <= 1'b0;
      end else if (!r_win) begin
         r_warn <= 1'b1;
         r_win  <= 1'b1;
      end else if ((r_state == ST_RUN) && r_tick) begin
         r_warn <= ~r_warn;
      end
   end

   assign o_warn = r_warn;
`else
   assign o_warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_time_ctrl.sv
// Bench for game_time_ctrl: FSM vector table, hand-built timing sequences and a randomized
// run against a cycle-level reference model, with a behavioural BCD timer closing the loop.
module tb_game_time_ctrl;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        game_over = 1'b0;
   logic        max_flag = 1'b0;
   logic [11:0] lim = 12'h000;
   logic [3:0]  d_u, d_t, d_h;
   logic        trst, tick, timeout, warn;
   logic [1:0]  st;
   int          tb_time = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      bit       s, p, g, m;
      bit [1:0] e_st;
      bit       e_trst;
   } vec_t;

   vec_t        tbl[19];
   logic [11:0] lims[4];

   always #5 clk = ~clk;

   assign d_u = 4'(tb_time % 10);
   assign d_t = 4'((tb_time / 10) % 10);
   assign d_h = 4'(tb_time / 100);

   // Behavioural 3-digit seconds timer: held at 0 by time_rst low, advances on tick_1s.
   always @(posedge clk or posedge rst) begin
      if (rst)                        tb_time <= 0;
      else if (!trst)                 tb_time <= 0;
      else if (tick && tb_time < 999) tb_time <= tb_time + 1;
   end

   game_time_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(3), .WARN_SECS(10)) dut (
      .i_sys_clk       (clk),
      .i_sys_rst       (rst),
      .i_start         (start),
      .i_pause         (pause),
      .i_game_over     (game_over),
      .i_time_1s       (d_u),
      .i_time_10s      (d_t),
      .i_time_100s     (d_h),
      .i_time_max_flag (max_flag),
      .i_limit_bcd     (lim),
      .o_time_rst      (trst),
      .o_tick_1s       (tick),
      .o_state         (st),
      .o_timeout       (timeout),
      .o_warn          (warn)
   );

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0; max_flag = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int n;
      int m_st, m_el, m_tick, m_to, m_trst, m_warn, m_win;
      int n_st, n_el, n_tick, n_to, n_trst, n_warn, n_win, lv;
`ifdef GAME_TIME_WARN_EN
      int diff;
`endif

      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      lims[0] = 12'h000; lims[1] = 12'h003; lims[2] = 12'h005; lims[3] = 12'h012;

      // Outputs while reset is held
      cyc(2);
      chk("rst_state", st, 2'd0);
      chk("rst_time_rst", trst, 1'b0);
      chk("rst_tick", tick, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_warn", warn, 1'b0);
      rst = 1'b0;
      cyc(1);

      // FSM transition table, unlimited session
      for (int i = 0; i < 19; i++) begin
         start = tbl[i].s; pause = tbl[i].p; game_over = tbl[i].g; max_flag = tbl[i].m;
         cyc(1);
         chk($sformatf("tbl_state[%0d]", i), st, tbl[i].e_st);
         chk($sformatf("tbl_time_rst[%0d]", i), trst, tbl[i].e_trst);
      end
      start = 1'b0; pause = 1'b0; game_over = 1'b0; max_flag = 1'b0;

      // Tick period and timer advance
      do_reset();
      start = 1'b1; cyc(1); start = 1'b0;
      chk("run_state", st, 2'd1);
      chk("run_time_rst", trst, 1'b1);
      chk("run_tick0", tick, 1'b0);
      for (int k = 1; k <= 13; k++) begin
         cyc(1);
         chk($sformatf("tick_cyc%0d", k), tick, (k % CLK_DIV) == 0);
         if (k == 5 || k == 9 || k == 13) chk("timer_count", tb_time, (k - 1) / CLK_DIV);
      end

      // Pause preserves the fractional second
      do_reset();
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      pause = 1'b1; cyc(1); pause = 1'b0;
      chk("pause_state", st, 2'd2);
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         chk("pause_no_tick", tick, 1'b0);
      end
      pause = 1'b1; cyc(1); pause = 1'b0;
      chk("resume_state", st, 2'd1);
      chk("resume_tick_a", tick, 1'b0);
      cyc(1);
      chk("resume_tick_b", tick, 1'b0);
      cyc(1);
      chk("resume_tick_c", tick, 1'b1);

      // Time limit 005
      do_reset();
      lim = 12'h005;
      start = 1'b1; cyc(1); start = 1'b0;
      n = 0;
      while (tb_time != 5 && n < 100) begin
         cyc(1);
         n++;
      end
      chk("limit_reached_in_budget", n < 100, 1'b1);
      chk("limit_timeout_pre", timeout, 1'b0);
      chk("limit_state_pre", st, 2'd1);
      cyc(1);
      chk("limit_timeout", timeout, 1'b1);
      chk("limit_state_run", st, 2'd1);
      cyc(1);
      chk("limit_state_over", st, 2'd3);
      for (int k = 0; k < 10; k++) begin
         cyc(1);
         chk("over_no_tick", tick, 1'b0);
         chk("over_timer_hold", tb_time, 5);
      end
      start = 1'b1; cyc(1); start = 1'b0;
      chk("ack_state", st, 2'd0);
      chk("ack_timeout", timeout, 1'b0);
      chk("ack_time_rst", trst, 1'b0);
      cyc(1);
      chk("ack_timer_clear", tb_time, 0);
      lim = 12'h000;

      // Randomized sessions against the reference model
      do_reset();
      m_st = 0; m_el = 0; m_tick = 0; m_to = 0; m_trst = 0; m_warn = 0; m_win = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) lim = lims[$urandom_range(0, 3)];
         start     = ($urandom_range(0, 9) == 0);
         pause     = ($urandom_range(0, 11) == 0);
         game_over = ($urandom_range(0, 49) == 0);
         max_flag  = ($urandom_range(0, 99) == 0);
         lv = lim[11:8] * 100 + lim[7:4] * 10 + lim[3:0];

         case (m_st)
            0:       n_st = start ? 1 : 0;
            1:       n_st = (game_over || m_to != 0 || max_flag) ? 3 : (pause ? 2 : 1);
            2:       n_st = game_over ? 3 : (pause ? 1 : 2);
            default: n_st = start ? 0 : 3;
         endcase
         n_tick = (m_st == 1 && m_el == CLK_DIV - 1);
         n_el   = (m_st == 1) ? (m_el + 1) % CLK_DIV : ((m_st == 2) ? m_el : 0);
         n_to   = (n_st == 0) ? 0 : ((m_to != 0) || (m_st == 1 && lv != 0 && tb_time == lv));
         n_trst = (n_st != 0);
`ifdef GAME_TIME_WARN_EN
         diff = lv - tb_time;
         if (!(m_st == 1 || m_st == 2) || lv == 0 || diff <= 0 || diff > 10) begin
            n_warn = 0; n_win = 0;
         end else if (m_win == 0) begin
            n_warn = 1; n_win = 1;
         end else begin
            n_win  = 1;
            n_warn = (m_st == 1 && m_tick != 0) ? (m_warn == 0) : m_warn;
         end
`else
         n_warn = 0; n_win = 0;
`endif
         cyc(1);
         m_st = n_st; m_el = n_el; m_tick = n_tick; m_to = n_to;
         m_trst = n_trst; m_warn = n_warn; m_win = n_win;
         chk("rnd_state", st, m_st);
         chk("rnd_tick", tick, m_tick);
         chk("rnd_time_rst", trst, m_trst);
         chk("rnd_timeout", timeout, m_to);
         chk("rnd_warn", warn, m_warn);
      end
      start = 1'b0; pause = 1'b0; game_over = 1'b0; max_flag = 1'b0; lim = 12'h000;

      // Asynchronous reset in the middle of a running second
      do_reset();
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(CLK_DIV);
      chk("pre_async_tick", tick, 1'b1);
      #3 rst = 1'b1;
      #1;
      chk("async_state", st, 2'd0);
      chk("async_time_rst", trst, 1'b0);
      chk("async_tick", tick, 1'b0);
      chk("async_timeout", timeout, 1'b0);
      chk("async_warn", warn, 1'b0);
      cyc(1);
      rst = 1'b0;
      cyc(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
